// File: rtl/gpr_sb_pkg.sv
// gpr_sb_pkg
// Shared constants for the general-purpose register file with scoreboard.
// Holds the default data/address widths and read-port count, plus a helper
// that sizes the busy counter (one more bit than the address so that a
// fully busy file, 2**ADDR_W entries, is representable).
package gpr_sb_pkg;

    localparam int GPR_DATA_W = 32;
    localparam int GPR_ADDR_W = 5;
    localparam int GPR_NUM_RD = 3;

    function automatic int busy_cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage : gpr_sb_pkg

// File: rtl/gpr_sb_rdport.sv
// gpr_sb_rdport
// One combinational read port of the register file.
//   i_mem      : current register contents (all entries)
//   i_busy     : current busy bit per register
//   i_rd_addr  : register index read by this port
//   i_wr_en    : writeback valid (already gated off while in reset)
//   i_wr_addr  : writeback destination
//   i_wr_data  : writeback data, forwarded when it hits this port's address
//   o_rd_data  : read data after bypass and zero-register masking
//   o_rd_busy  : busy flag after bypass and zero-register masking
module gpr_sb_rdport
    import gpr_sb_pkg::*;
#(
    parameter int DATA_W   = GPR_DATA_W,
    parameter int ADDR_W   = GPR_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [DATA_W-1:0]      i_mem [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]   i_busy,
    input  logic [ADDR_W-1:0]      i_rd_addr,
    input  logic                   i_wr_en,
    input  logic [ADDR_W-1:0]      i_wr_addr,
    input  logic [DATA_W-1:0]      i_wr_data,
    output logic [DATA_W-1:0]      o_rd_data,
    output logic                   o_rd_busy
);

    logic wr_hit;
    logic zero_hit;

    always_comb begin
        wr_hit    = (BYPASS != 0) && i_wr_en && (i_wr_addr == i_rd_addr);
        zero_hit  = (ZERO_REG != 0) && (i_rd_addr == '0);
        o_rd_data = i_mem[i_rd_addr];
        o_rd_busy = i_busy[i_rd_addr];
        // A writeback landing this cycle both supplies the data and retires
        // the pending result, so the reader sees it as not busy.
        if (wr_hit) begin
            o_rd_data = i_wr_data;
            o_rd_busy = 1'b0;
        end
        // The hardwired zero register overrides even a forwarded value.
        if (zero_hit) begin
            o_rd_data = '0;
            o_rd_busy = 1'b0;
        end
    end

endmodule : gpr_sb_rdport

// File: rtl/gpr_sb.sv
// gpr_sb
// Multi-ported register file with a per-register busy scoreboard.
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   i_rd_addr         : NUM_RD packed read addresses, port k in slice k
//   o_rd_data         : NUM_RD packed read data words (combinational)
//   o_rd_busy         : per-port "addressed register awaits writeback"
//   i_wr_en/addr/data : writeback port, writes data and retires busy
//   i_issue_en/addr   : request to mark a destination register busy
//   o_issue_ready     : the requested destination may be marked busy now
//   o_busy_count      : registered count of busy registers
module gpr_sb
    import gpr_sb_pkg::*;
#(
    parameter int DATA_W   = GPR_DATA_W,
    parameter int ADDR_W   = GPR_ADDR_W,
    parameter int NUM_RD   = GPR_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
    output logic [NUM_RD-1:0]          o_rd_busy,
    input  logic                       i_wr_en,
    input  logic [ADDR_W-1:0]          i_wr_addr,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_issue_en,
    input  logic [ADDR_W-1:0]          i_issue_addr,
    output logic                       o_issue_ready,
    output logic [ADDR_W:0]            o_busy_count
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = busy_cnt_w(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  busy_count_q;
    logic [CNT_W-1:0]  busy_count_d;

    logic wr_en_eff;
    logic wr_zero;
    logic issue_zero;
    logic wr_hit_issue;
    logic issue_ready;
    logic issue_acc;
    logic cnt_inc;
    logic cnt_dec;

    // Control decode: writes and issues are ignored while reset is held,
    // and the gated write enable also keeps bypass from leaking data onto
    // the read ports during reset.
    always_comb begin
        wr_en_eff    = i_wr_en & ~reset;
        wr_zero      = (ZERO_REG != 0) && (i_wr_addr == '0);
        issue_zero   = (ZERO_REG != 0) && (i_issue_addr == '0);
        wr_hit_issue = wr_en_eff && (i_wr_addr == i_issue_addr);
        // A busy destination can be re-issued in the same cycle its pending
        // writeback arrives; the zero register is always "ready" since the
        // issue is simply dropped.
        issue_ready  = reset || !busy_q[i_issue_addr] || wr_hit_issue || issue_zero;
        issue_acc    = i_issue_en && !reset && issue_ready && !issue_zero;
        // Counter tracks actual bit transitions: a new issue only counts if
        // the bit was clear, and a writeback only retires a set bit when a
        // same-address issue is not re-arming it.
        cnt_inc      = issue_acc && !busy_q[i_issue_addr];
        cnt_dec      = wr_en_eff && busy_q[i_wr_addr] && !(issue_acc && wr_hit_issue);
    end

    // Next-state: clear on writeback first so a same-cycle issue wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_eff) begin
            busy_d[i_wr_addr] = 1'b0;
        end
        if (issue_acc) begin
            busy_d[i_issue_addr] = 1'b1;
        end
        busy_count_d = busy_count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en_eff && !wr_zero) begin
            mem_d[i_wr_addr] = i_wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        gpr_sb_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdport (
            .i_mem     (mem_q),
            .i_busy    (busy_q),
            .i_rd_addr (i_rd_addr[k*ADDR_W +: ADDR_W]),
            .i_wr_en   (wr_en_eff),
            .i_wr_addr (i_wr_addr),
            .i_wr_data (i_wr_data),
            .o_rd_data (o_rd_data[k*DATA_W +: DATA_W]),
            .o_rd_busy (o_rd_busy[k])
        );
    end

    assign o_issue_ready = issue_ready;
    assign o_busy_count  = busy_count_q;

endmodule : gpr_sb

// File: tb/tb_gpr_sb.sv
// tb_gpr_sb
// Self-checking bench for gpr_sb: directed table of scoreboard scenarios,
// a mid-operation asynchronous reset sequence, and randomized traffic
// compared against a behavioural register-file/scoreboard model.
module tb_gpr_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 3;
    localparam int DEPTH = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NR*AW-1:0]  i_rd_addr;
    logic [NR*DW-1:0]  o_rd_data;
    logic [NR-1:0]     o_rd_busy;
    logic              i_wr_en;
    logic [AW-1:0]     i_wr_addr;
    logic [DW-1:0]     i_wr_data;
    logic              i_issue_en;
    logic [AW-1:0]     i_issue_addr;
    logic              o_issue_ready;
    logic [AW:0]       o_busy_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];

    gpr_sb #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_rd_busy     (o_rd_busy),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .i_issue_en    (i_issue_en),
        .i_issue_addr  (i_issue_addr),
        .o_issue_ready (o_issue_ready),
        .o_busy_count  (o_busy_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          ie;
        logic [4:0]  ia;
        logic [4:0]  ra;
        logic [31:0] exp_data;
        bit          exp_busy;
        bit          exp_ready;
        int          exp_cnt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Apply the architectural rules for one clock edge using the inputs
    // currently on the pins and the pre-edge model state.
    task automatic model_edge();
        bit ready;
        bit acc;
        ready = !m_busy[i_issue_addr] || (i_wr_en && i_wr_addr == i_issue_addr) || (i_issue_addr == 0);
        acc   = i_issue_en && ready && (i_issue_addr != 0);
        if (i_wr_en && i_wr_addr != 0) m_mem[i_wr_addr] = i_wr_data;
        if (i_wr_en) m_busy[i_wr_addr] = 1'b0;
        if (acc) m_busy[i_issue_addr] = 1'b1;
    endtask

    task automatic drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input bit ie, input logic [4:0] ia,
                         input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2);
        i_wr_en      = we;
        i_wr_addr    = wa;
        i_wr_data    = wd;
        i_issue_en   = ie;
        i_issue_addr = ia;
        i_rd_addr    = {ra2, ra1, ra0};
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic check_all(input string tag);
        bit exp_ready;
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] ra;
            logic [DW-1:0] ed;
            bit            eb;
            ra = i_rd_addr[k*AW +: AW];
            if (ra == 0) begin
                ed = '0; eb = 1'b0;
            end else if (i_wr_en && i_wr_addr == ra) begin
                ed = i_wr_data; eb = 1'b0;
            end else begin
                ed = m_mem[ra]; eb = m_busy[ra];
            end
            chk({tag, "_data"}, o_rd_data[k*DW +: DW], ed);
            chk({tag, "_busy"}, o_rd_busy[k], eb);
        end
        exp_ready = !m_busy[i_issue_addr] || (i_wr_en && i_wr_addr == i_issue_addr) || (i_issue_addr == 0);
        chk({tag, "_ready"}, o_issue_ready, exp_ready);
        chk({tag, "_count"}, o_busy_count, m_count());
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        // we  wa  wd            ie  ia  ra  data          busy ready cnt
        tbl[0]  = '{0, 0, 32'h0,        1, 5, 5, 32'h0,        0, 1, 0};
        tbl[1]  = '{0, 0, 32'h0,        0, 5, 5, 32'h0,        1, 0, 1};
        tbl[2]  = '{1, 5, 32'hDEADBEEF, 0, 5, 5, 32'hDEADBEEF, 0, 1, 1};
        tbl[3]  = '{0, 0, 32'h0,        0, 5, 5, 32'hDEADBEEF, 0, 1, 0};
        tbl[4]  = '{0, 0, 32'h0,        1, 7, 7, 32'h0,        0, 1, 0};
        tbl[5]  = '{0, 0, 32'h0,        1, 7, 7, 32'h0,        1, 0, 1};
        tbl[6]  = '{0, 0, 32'h0,        0, 7, 7, 32'h0,        1, 0, 1};
        tbl[7]  = '{1, 7, 32'h11112222, 1, 7, 7, 32'h11112222, 0, 1, 1};
        tbl[8]  = '{0, 0, 32'h0,        0, 7, 7, 32'h11112222, 1, 0, 1};
        tbl[9]  = '{1, 7, 32'h33334444, 0, 7, 7, 32'h33334444, 0, 1, 1};
        tbl[10] = '{1, 0, 32'h12345678, 1, 0, 0, 32'h0,        0, 1, 0};
        tbl[11] = '{0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 1, 0};

        drive(1, 4, 32'hFFFF0000, 1, 4, 4, 4, 4);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        // While in reset: issues always ready, writes invisible, nothing busy
        chk("in_reset_ready", o_issue_ready, 1'b1);
        chk("in_reset_data", o_rd_data[DW-1:0], 32'h0);
        chk("in_reset_count", o_busy_count, 6'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;

        // Post-reset sweep of every address on every port
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, 0, 0, 5'(a), 5'(a), 5'((a + 1) % DEPTH), 5'((a + 2) % DEPTH));
            #1;
            for (int k = 0; k < NR; k++) begin
                chk("sweep_data", o_rd_data[k*DW +: DW], 32'h0);
                chk("sweep_busy", o_rd_busy[k], 1'b0);
            end
            chk("sweep_ready", o_issue_ready, 1'b1);
            chk("sweep_count", o_busy_count, 6'd0);
        end

        // Directed scoreboard scenarios
        @(posedge clock);
        #1;
        for (int r = 0; r < 12; r++) begin
            drive(tbl[r].we, tbl[r].wa, tbl[r].wd, tbl[r].ie, tbl[r].ia, tbl[r].ra, tbl[r].ra, tbl[r].ra);
            #3;
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("tbl%0d_data", r), o_rd_data[k*DW +: DW], tbl[r].exp_data);
                chk($sformatf("tbl%0d_busy", r), o_rd_busy[k], tbl[r].exp_busy);
            end
            chk($sformatf("tbl%0d_ready", r), o_issue_ready, tbl[r].exp_ready);
            chk($sformatf("tbl%0d_count", r), o_busy_count, 6'(tbl[r].exp_cnt));
            cycle();
        end

        // Issue r1..r15 (r3 written along the way), then reset mid-sequence
        for (int r = 1; r <= 15; r++) begin
            drive(r == 6, 3, 32'hA5A5A5A5, 1, 5'(r), 3, 5'(r), 1);
            #3;
            check_all("seq");
            cycle();
        end
        drive(0, 0, 0, 1, 1, 3, 1, 3);
        #1;
        check_all("pre_rst");
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst_r3", o_rd_data[DW-1:0], 32'h0);
        chk("async_rst_r1", o_rd_data[2*DW-1:DW], 32'h0);
        chk("async_rst_busy", o_rd_busy, 3'b000);
        chk("async_rst_count", o_busy_count, 6'd0);
        chk("async_rst_ready", o_issue_ready, 1'b1);
        @(posedge clock);
        #1;
        for (int a = 0; a < DEPTH; a++) begin
            drive(1, 5'(a), 32'hBAD0BAD0, 1, 5'(a), 5'(a), 5'(a), 5'(a));
            #1;
            chk("rst_hold_data", o_rd_data[DW-1:0], 32'h0);
            chk("rst_hold_busy", o_rd_busy[0], 1'b0);
            chk("rst_hold_ready", o_issue_ready, 1'b1);
            chk("rst_hold_count", o_busy_count, 6'd0);
        end
        @(posedge clock);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;

        // First edge after release must act normally
        drive(1, 9, 32'hCAFEF00D, 1, 10, 9, 10, 0);
        #2;
        check_all("post_rst");
        cycle();
        drive(0, 0, 0, 0, 10, 9, 10, 0);
        #2;
        check_all("post_rst2");
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 9) < 4, pick(), $urandom, $urandom_range(0, 1) == 1, pick(),
                  pick(), pick(), pick());
            #3;
            check_all("rand");
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gpr_sb
